// File: rtl/button_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
//   Multi-channel synchronizer + debouncer for raw pushbutton / switch pads.
//   Each channel: optional polarity inversion, SYNC_STAGES-deep synchronizer,
//   and an independent 4-state FSM that accepts a level change only after
//   STABLE_CYCLES consecutive identical synchronized samples.
//
// Ports
//   async_reset    in   1         asynchronous reset, active-low
//   clk            in   1         system clock
//   signal_input   in   CHANNELS  raw pad levels, asynchronous to clk
//   signal_output  out  CHANNELS  debounced level, active-high, registered
//   busy           out  CHANNELS  high while a change is being qualified
// ---------------------------------------------------------------------------
module button_debouncer #(
    parameter int CHANNELS      = 3,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 500000,
    parameter int COUNTER_WIDTH = 20,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic                async_reset,
    input  logic                clk,
    input  logic [CHANNELS-1:0] signal_input,
    output logic [CHANNELS-1:0] signal_output,
    output logic [CHANNELS-1:0] busy
);

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_RISE = 2'd1,
        S_HIGH = 2'd2,
        S_FALL = 2'd3
    } state_t;

    localparam logic                     LP_INVERT = (ACTIVE_LOW != 0);
    localparam logic [COUNTER_WIDTH-1:0] LP_LAST   = COUNTER_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [COUNTER_WIDTH-1:0] LP_ONE    = COUNTER_WIDTH'(1);

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [SYNC_STAGES-1:0]   r_sync;
        state_t                   r_state;
        state_t                   w_state_nxt;
        logic [COUNTER_WIDTH-1:0] r_cnt;
        logic [COUNTER_WIDTH-1:0] w_cnt_nxt;
        logic                     r_out;
        logic                     r_busy;
        logic                     w_p;
        logic                     w_s;

        // Inversion precedes the first flop so reset (all zeros) is the
        // inactive level regardless of pad polarity.
        assign w_p = signal_input[gi] ^ LP_INVERT;
        assign w_s = r_sync[SYNC_STAGES-1];

        always_ff @(posedge clk or negedge async_reset) begin
            if (!async_reset) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], w_p};
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            unique case (r_state)
                S_LOW: begin
                    if (w_s) begin
                        w_state_nxt = S_RISE;
                        w_cnt_nxt   = LP_ONE;
                    end else begin
                        w_cnt_nxt   = '0;
                    end
                end
                S_RISE: begin
                    if (!w_s) begin
                        w_state_nxt = S_LOW;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == LP_LAST) begin
                        w_state_nxt = S_HIGH;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + LP_ONE;
                    end
                end
                S_HIGH: begin
                    if (!w_s) begin
                        w_state_nxt = S_FALL;
                        w_cnt_nxt   = LP_ONE;
                    end
                end
                S_FALL: begin
                    if (w_s) begin
                        w_state_nxt = S_HIGH;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == LP_LAST) begin
                        w_state_nxt = S_LOW;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + LP_ONE;
                    end
                end
                default: begin
                    w_state_nxt = S_LOW;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        // Outputs are decoded from the next state so they register on the
        // same edge as the state change, without an extra pipeline stage.
        always_ff @(posedge clk or negedge async_reset) begin
            if (!async_reset) begin
                r_state <= S_LOW;
                r_cnt   <= '0;
                r_out   <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_out   <= (w_state_nxt == S_HIGH) || (w_state_nxt == S_FALL);
                r_busy  <= (w_state_nxt == S_RISE) || (w_state_nxt == S_FALL);
            end
        end

        assign signal_output[gi] = r_out;
        assign busy[gi]          = r_busy;
    end

endmodule

// File: tb/tb_button_debouncer.sv
// ---------------------------------------------------------------------------
// tb_button_debouncer
//   Directed bench for button_debouncer with CHANNELS=3, SYNC_STAGES=2,
//   STABLE_CYCLES=4, ACTIVE_LOW=1. Inputs change 1 ns after a rising edge;
//   outputs are sampled at that same point, i.e. just after edge e.
// ---------------------------------------------------------------------------
module tb_button_debouncer;

    logic       clk;
    logic       async_reset;
    logic [2:0] signal_input;
    logic [2:0] signal_output;
    logic [2:0] busy;

    int tests_run;
    int fails;

    button_debouncer #(
        .CHANNELS      (3),
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (4),
        .COUNTER_WIDTH (3),
        .ACTIVE_LOW    (1)
    ) dut (
        .async_reset   (async_reset),
        .clk           (clk),
        .signal_input  (signal_input),
        .signal_output (signal_output),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int e,
                         input logic [2:0] obs, input logic [2:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s e=%0d: observed %b expected %b", tag, e, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] bounce_pat;
        logic [2:0] eo;
        logic [2:0] eb;

        tests_run    = 0;
        fails        = 0;
        async_reset  = 1'b1;
        signal_input = 3'b111;

        // Reset asserted between edges, raw released
        #2 async_reset = 1'b0;
        #1;
        check("rst_out_now", 0, signal_output, 3'b000);
        check("rst_busy_now", 0, busy, 3'b000);
        for (int e = 1; e <= 10; e++) begin
            step();
            check("rst_out", e, signal_output, 3'b000);
            check("rst_busy", e, busy, 3'b000);
        end
        async_reset = 1'b1;
        for (int e = 0; e < 3; e++) step();
        check("idle_out", 0, signal_output, 3'b000);

        // Clean press on ch0
        signal_input = 3'b110;
        for (int e = 0; e <= 7; e++) begin
            step();
            eo = (e >= 5) ? 3'b001 : 3'b000;
            eb = (e >= 2 && e < 5) ? 3'b001 : 3'b000;
            check("press_out", e, signal_output, eo);
            check("press_busy", e, busy, eb);
        end

        // Two-cycle release glitch on ch0: output must hold
        signal_input = 3'b111;
        for (int e = 0; e <= 7; e++) begin
            if (e == 2) signal_input = 3'b110;
            step();
            eb = (e == 2 || e == 3) ? 3'b001 : 3'b000;
            check("glitch_out", e, signal_output, 3'b001);
            check("glitch_busy", e, busy, eb);
        end

        // Held release on ch0
        signal_input = 3'b111;
        for (int e = 0; e <= 7; e++) begin
            step();
            eo = (e < 5) ? 3'b001 : 3'b000;
            eb = (e >= 2 && e < 5) ? 3'b001 : 3'b000;
            check("release_out", e, signal_output, eo);
            check("release_busy", e, busy, eb);
        end

        // Bounce on ch1: raw 0,0,0,1,0,0,0,0 then held 0
        bounce_pat = 8'b0000_1000;
        for (int e = 0; e <= 11; e++) begin
            if (e < 8) signal_input[1] = bounce_pat[e];
            step();
            eo = (e >= 9) ? 3'b010 : 3'b000;
            eb = ((e >= 2 && e <= 4) || (e >= 6 && e <= 8)) ? 3'b010 : 3'b000;
            check("bounce_out", e, signal_output, eo);
            check("bounce_busy", e, busy, eb);
        end

        signal_input = 3'b111;
        for (int e = 0; e < 10; e++) step();
        check("settle1_out", 0, signal_output, 3'b000);
        check("settle1_busy", 0, busy, 3'b000);

        // Simultaneous: ch0+ch2 together, ch1 two cycles later
        for (int e = 0; e <= 9; e++) begin
            if (e == 0) signal_input = 3'b010;
            if (e == 2) signal_input = 3'b000;
            step();
            if (e < 5)       eo = 3'b000;
            else if (e < 7)  eo = 3'b101;
            else             eo = 3'b111;
            if (e == 2 || e == 3)      eb = 3'b101;
            else if (e == 4)           eb = 3'b111;
            else if (e == 5 || e == 6) eb = 3'b010;
            else                       eb = 3'b000;
            check("simul_out", e, signal_output, eo);
            check("simul_busy", e, busy, eb);
        end

        signal_input = 3'b111;
        for (int e = 0; e < 10; e++) step();
        check("settle2_out", 0, signal_output, 3'b000);
        check("settle2_busy", 0, busy, 3'b000);

        // Reset mid-count on ch0 (S_RISE, cnt = 2), raw held pressed
        signal_input = 3'b110;
        for (int e = 0; e <= 3; e++) step();
        check("mid_busy_pre", 3, busy, 3'b001);
        #1 async_reset = 1'b0;
        #1;
        check("mid_rst_out_now", 0, signal_output, 3'b000);
        check("mid_rst_busy_now", 0, busy, 3'b000);
        for (int e = 1; e <= 3; e++) begin
            step();
            check("mid_rst_out", e, signal_output, 3'b000);
            check("mid_rst_busy", e, busy, 3'b000);
        end
        async_reset = 1'b1;
        for (int e = 0; e <= 7; e++) begin
            step();
            eo = (e >= 5) ? 3'b001 : 3'b000;
            eb = (e >= 2 && e < 5) ? 3'b001 : 3'b000;
            check("mid_post_out", e, signal_output, eo);
            check("mid_post_busy", e, busy, eb);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
